// File: rtl/bus_initiator_if.sv
// Command, response and slave-bus signals of the single-outstanding initiator.
// master is the initiator side; slave is the command source plus the bus slave.
interface bus_initiator_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              cmd_write;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              bus_ss;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_bdone;

    modport master (
        input  cmd_valid, cmd_addr, cmd_wdata, cmd_write,
        input  rsp_ready, bus_rdata, bus_bdone,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output bus_ss, bus_we, bus_addr, bus_wdata
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_wdata, cmd_write,
        output rsp_ready, bus_rdata, bus_bdone,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  bus_ss, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/bus_initiator.sv
// Single-outstanding bus initiator: one command -> one slave-bus transaction
// -> one response, with a saturating cycle timeout on unresponsive slaves.
module bus_initiator #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic             clk,
    input logic             rst,
    bus_initiator_if.master bi
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bi.cmd_valid) begin
                    addr_d  = bi.cmd_addr;
                    wdata_d = bi.cmd_wdata;
                    write_d = bi.cmd_write;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    // Misaligned commands never reach the bus.
                    if (bi.cmd_addr[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bi.bus_bdone) begin
                    rdata_d = write_q ? '0 : bi.bus_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (TO_EN && cnt_q == LIMIT) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bi.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic ss;
    assign ss = (state_q == REQ);

    assign bi.cmd_ready = (state_q == IDLE);
    assign bi.rsp_valid = (state_q == RESP);
    assign bi.rsp_rdata = rdata_q;
    assign bi.rsp_err   = err_q;
    assign bi.bus_ss    = ss;
    assign bi.bus_we    = ss & write_q;
    assign bi.bus_addr  = ss ? addr_q : '0;
    assign bi.bus_wdata = ss ? wdata_q : '0;
endmodule

// File: tb/tb_bus_initiator.sv
// Directed self-checking bench for bus_initiator (TIMEOUT = 16).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_bus_initiator;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   ssc;

    bus_initiator_if #(.ADDR_W(32), .DATA_W(32)) bi ();

    bus_initiator #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bi (bi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d,
                         input logic w);
        chk("cmd_ready_idle", bi.cmd_ready, 1);
        bi.cmd_valid = 1'b1;
        bi.cmd_addr  = a;
        bi.cmd_wdata = d;
        bi.cmd_write = w;
        tick();
        bi.cmd_valid = 1'b0;
        bi.cmd_addr  = 32'hFFFF_FFFF;
        bi.cmd_wdata = 32'hFFFF_FFFF;
        bi.cmd_write = ~w;
    endtask

    // Assert bdone in the (wait_n+1)-th bus_ss cycle; wait_n < 0 = never.
    task automatic run_req(input int wait_n, output int ss_cycles);
        ss_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bi.bus_ss) break;
            ss_cycles++;
            bi.bus_bdone = (ss_cycles == wait_n + 1);
            tick();
        end
        bi.bus_bdone = 1'b0;
    endtask

    task automatic hold_rsp(input int n, input logic e,
                            input logic [31:0] rd);
        for (int i = 0; i < n; i++) begin
            bi.bus_rdata = 32'hA000_0000 + i;
            chk("stall_valid", bi.rsp_valid, 1);
            chk("stall_err", bi.rsp_err, e);
            chk("stall_rdata", bi.rsp_rdata, rd);
            chk("stall_cmd_ready", bi.cmd_ready, 0);
            chk("stall_ss", bi.bus_ss, 0);
            tick();
        end
        chk("pre_hs_valid", bi.rsp_valid, 1);
        bi.rsp_ready = 1'b1;
        tick();
        bi.rsp_ready = 1'b0;
        chk("post_hs_cmd_ready", bi.cmd_ready, 1);
        chk("post_hs_valid", bi.rsp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        bi.cmd_valid = 1'b0;
        bi.cmd_addr  = '0;
        bi.cmd_wdata = '0;
        bi.cmd_write = 1'b0;
        bi.rsp_ready = 1'b0;
        bi.bus_rdata = '0;
        bi.bus_bdone = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_cmd_ready", bi.cmd_ready, 1);
        chk("rst_rsp_valid", bi.rsp_valid, 0);
        chk("rst_rsp_err", bi.rsp_err, 0);
        chk("rst_rsp_rdata", bi.rsp_rdata, 0);
        chk("rst_ss", bi.bus_ss, 0);
        chk("rst_we", bi.bus_we, 0);
        chk("rst_addr", bi.bus_addr, 0);
        chk("rst_wdata", bi.bus_wdata, 0);

        // Write 0xA5 to 0x08, single-cycle slave.
        bi.bus_rdata = 32'hDEAD_BEEF;
        issue(32'h08, 32'hA5, 1'b1);
        chk("wr_ss", bi.bus_ss, 1);
        chk("wr_we", bi.bus_we, 1);
        chk("wr_addr", bi.bus_addr, 32'h08);
        chk("wr_wdata", bi.bus_wdata, 32'hA5);
        chk("wr_cmd_ready", bi.cmd_ready, 0);
        chk("wr_valid_early", bi.rsp_valid, 0);
        run_req(0, ssc);
        chk("wr_ss_cycles", ssc, 1);
        chk("wr_valid_n2", bi.rsp_valid, 1);
        chk("wr_err", bi.rsp_err, 0);
        chk("wr_rdata", bi.rsp_rdata, 0);
        chk("wr_idle_we", bi.bus_we, 0);
        chk("wr_idle_addr", bi.bus_addr, 0);
        chk("wr_idle_wdata", bi.bus_wdata, 0);
        hold_rsp(0, 1'b0, 32'h0);

        // Read 0x0C, three wait cycles, then a 10-cycle response stall.
        bi.bus_rdata = 32'h3C;
        issue(32'h0C, 32'h1111_2222, 1'b0);
        chk("rd_we", bi.bus_we, 0);
        chk("rd_addr", bi.bus_addr, 32'h0C);
        run_req(3, ssc);
        chk("rd_ss_cycles", ssc, 4);
        chk("rd_valid", bi.rsp_valid, 1);
        chk("rd_rdata", bi.rsp_rdata, 32'h3C);
        chk("rd_err", bi.rsp_err, 0);
        hold_rsp(10, 1'b0, 32'h3C);

        // Timeout: slave never completes.
        bi.bus_rdata = 32'h55;
        issue(32'h10, 32'h0, 1'b0);
        run_req(-1, ssc);
        chk("to_ss_cycles", ssc, 16);
        chk("to_valid", bi.rsp_valid, 1);
        chk("to_err", bi.rsp_err, 1);
        chk("to_rdata", bi.rsp_rdata, 0);
        hold_rsp(2, 1'b1, 32'h0);

        // bdone on the 16th cycle beats the timeout.
        bi.bus_rdata = 32'h77;
        issue(32'h20, 32'h0, 1'b0);
        run_req(15, ssc);
        chk("lim_ss_cycles", ssc, 16);
        chk("lim_err", bi.rsp_err, 0);
        chk("lim_rdata", bi.rsp_rdata, 32'h77);
        hold_rsp(0, 1'b0, 32'h77);

        // Misaligned address 0x06: immediate error, no bus activity.
        issue(32'h06, 32'hCAFE, 1'b1);
        chk("mis_valid_n1", bi.rsp_valid, 1);
        chk("mis_err", bi.rsp_err, 1);
        chk("mis_rdata", bi.rsp_rdata, 0);
        chk("mis_we", bi.bus_we, 0);
        hold_rsp(10, 1'b1, 32'h0);

        // Reset while the transaction is active.
        issue(32'h14, 32'h0, 1'b0);
        chk("rr_ss1", bi.bus_ss, 1);
        tick();
        chk("rr_ss2", bi.bus_ss, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rr_ss_after", bi.bus_ss, 0);
        chk("rr_cmd_ready", bi.cmd_ready, 1);
        bi.bus_bdone = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("rr_no_rsp", bi.rsp_valid, 0);
            tick();
        end
        bi.bus_bdone = 1'b0;

        // Normal command after the aborted one.
        bi.bus_rdata = 32'h9999;
        issue(32'h18, 32'h1234, 1'b1);
        chk("nx_we", bi.bus_we, 1);
        chk("nx_wdata", bi.bus_wdata, 32'h1234);
        chk("nx_addr", bi.bus_addr, 32'h18);
        run_req(1, ssc);
        chk("nx_ss_cycles", ssc, 2);
        chk("nx_err", bi.rsp_err, 0);
        chk("nx_rdata", bi.rsp_rdata, 0);
        hold_rsp(1, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
